fir_host_seq: RTL



---
 rtl/fir_host_seq_pkg.sv | 54 +++++
 rtl/fir_tap_buf.sv | 68 ++++++
 rtl/fir_host_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_host_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_host_seq_pkg
// Description : Shared definitions for the FIR host configuration sequencer.
//               Contains the config_valid beat codes, controller command
//               codes, controller state codes (as reported on status[1:0])
//               and the sequencer state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_host_seq_pkg;

  // Beat type on config_valid
  localparam logic [1:0] CV_NONE    = 2'd0;
  localparam logic [1:0] CV_SETTING = 2'd1;
  localparam logic [1:0] CV_COMMAND = 2'd2;
  localparam logic [1:0] CV_TAP     = 2'd3;

  // Commands carried on input_command
  localparam logic [31:0] CMD_START  = 32'd1;
  localparam logic [31:0] CMD_STOP   = 32'd2;
  localparam logic [31:0] CMD_RETURN = 32'd3;

  // Controller state as reported on status[1:0]
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CHK0       = 4'd1,
    S_SETCFG     = 4'd2,
    S_TAPS       = 4'd3,
    S_START      = 4'd4,
    S_WAIT_RUN   = 4'd5,
    S_RUN        = 4'd6,
    S_STOP       = 4'd7,
    S_WAIT_DRAIN = 4'd8,
    S_RET        = 4'd9,
    S_WAIT_IDLE  = 4'd10
  } seq_state_t;

  // Index width for a buffer of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Return command: flush code sits just above the RETURN opcode.
  function automatic logic [31:0] ret_command(input logic [1:0] flush);
    return {28'd0, flush, CMD_RETURN[1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_buf.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap_buf
// Description : NUM_TAPS x 32 tap register file with an append-only write
//               pointer and an asynchronous read index.
// Ports       : clk, rst_n   - clock, synchronous active-low reset
//               wr_en        - write request (already qualified by caller)
//               wr_data      - tap value to append
//               clr_ptr      - rewind write pointer (contents are kept)
//               rd_idx       - read index
//               rd_data      - tap value at rd_idx
//               full         - registered: write pointer == NUM_TAPS
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_buf
  import fir_host_seq_pkg::*;
#(
  parameter int NUM_TAPS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [31:0]                      wr_data,
  input  logic                             clr_ptr,
  input  logic [idx_width(NUM_TAPS)-1:0]   rd_idx,
  output logic [31:0]                      rd_data,
  output logic                             full
);

  localparam int IDX_W = idx_width(NUM_TAPS);
  localparam int PTR_W = $clog2(NUM_TAPS + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_TAPS);

  logic [PTR_W-1:0] r_ptr;
  logic [31:0]      r_mem [NUM_TAPS];
  logic             w_wr_ok;
  logic [PTR_W-1:0] w_ptr_inc;

  // Writes past the end are silently dropped.
  assign w_wr_ok   = wr_en && (r_ptr != PTR_MAX);
  assign w_ptr_inc = r_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      full  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        r_mem[r_ptr[IDX_W-1:0]] <= wr_data;
      end
      // Rewind has priority over advancing; the written data still lands.
      if (clr_ptr) begin
        r_ptr <= '0;
        full  <= 1'b0;
      end else if (w_wr_ok) begin
        r_ptr <= w_ptr_inc;
        full  <= (w_ptr_inc == PTR_MAX);
      end
    end
  end

  assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/fir_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : fir_host_seq
// Description : Host-side configuration sequencer for the FIR controller.
//               Latches a setting word and tap buffer from the host port,
//               then runs load setting / stream taps / start, and later
//               stop / wait drain / return, with a timeout on every wait.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               host_setting        - setting word, latched on go
//               host_tap_wr/_data   - append a tap (IDLE only)
//               host_go, host_stop  - sequence triggers
//               host_flush          - flush code, latched on stop
//               busy, tap_full, done, running, error - host status
//               input_config, input_command, config_tap, config_valid
//                                   - beats to the controller
//               status              - controller state in [1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module fir_host_seq
  import fir_host_seq_pkg::*;
#(
  parameter int NUM_TAPS = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] host_setting,
  input  logic        host_tap_wr,
  input  logic [31:0] host_tap_data,
  input  logic        host_go,
  input  logic        host_stop,
  input  logic [1:0]  host_flush,
  output logic        busy,
  output logic        tap_full,
  output logic        done,
  output logic        running,
  output logic        error,
  output logic [31:0] input_config,
  output logic [31:0] input_command,
  output logic [31:0] config_tap,
  output logic [1:0]  config_valid,
  input  logic [31:0] status
);

  localparam int IDX_W = idx_width(NUM_TAPS);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  seq_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [TO_W-1:0]  r_tmo, w_tmo_nxt;
  logic [31:0]      r_setting;
  logic [1:0]       r_flush;
  logic             w_go_acc, w_stop_acc, w_timeout, w_done_nxt, w_err_nxt;
  logic             w_waiting;
  logic [1:0]       w_cv;
  logic [31:0]      w_cfg, w_cmd, w_tap;
  logic [31:0]      w_buf_rd;
  logic [1:0]       w_ctl;
  logic             w_unused_status;

  assign w_ctl           = status[1:0];
  assign w_unused_status = ^status[31:2];

  fir_tap_buf #(
    .NUM_TAPS (NUM_TAPS)
  ) u_tap_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (host_tap_wr && (r_state == S_IDLE)),
    .wr_data (host_tap_data),
    .clr_ptr (w_go_acc),
    .rd_idx  (w_idx_nxt),
    .rd_data (w_buf_rd),
    .full    (tap_full)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_go_acc    = 1'b0;
    w_stop_acc  = 1'b0;
    w_timeout   = 1'b0;
    w_done_nxt  = 1'b0;
    w_waiting   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // go wins over a simultaneous stop; stop alone is meaningless here
        if (host_go) begin
          w_go_acc    = 1'b1;
          w_state_nxt = S_CHK0;
        end
      end
      S_CHK0: begin
        w_waiting = 1'b1;
        if (w_ctl == ST_IDLE) w_state_nxt = S_SETCFG;
        else if (r_tmo == TO_LAST) w_timeout = 1'b1;
      end
      S_SETCFG: begin
        w_state_nxt = S_TAPS;
        w_idx_nxt   = '0;
      end
      S_TAPS: begin
        if (r_idx == LAST_IDX) w_state_nxt = S_START;
        else w_idx_nxt = r_idx + IDX_W'(1);
      end
      S_START: w_state_nxt = S_WAIT_RUN;
      S_WAIT_RUN: begin
        w_waiting = 1'b1;
        if (w_ctl == ST_RUN) w_state_nxt = S_RUN;
        else if (r_tmo == TO_LAST) w_timeout = 1'b1;
      end
      S_RUN: begin
        if (host_stop) begin
          w_stop_acc  = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: w_state_nxt = S_WAIT_DRAIN;
      S_WAIT_DRAIN: begin
        w_waiting = 1'b1;
        if (w_ctl == ST_READY) w_state_nxt = S_RET;
        else if (r_tmo == TO_LAST) w_timeout = 1'b1;
      end
      S_RET: w_state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        w_waiting = 1'b1;
        if (w_ctl == ST_IDLE) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_tmo == TO_LAST) begin
          w_timeout = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_timeout) w_state_nxt = S_IDLE;

    // Counter restarts on every state change, so each wait begins at zero.
    if (w_state_nxt != r_state) w_tmo_nxt = '0;
    else if (w_waiting)         w_tmo_nxt = r_tmo + TO_W'(1);
    else                        w_tmo_nxt = r_tmo;

    if (w_go_acc)       w_err_nxt = 1'b0;
    else if (w_timeout) w_err_nxt = 1'b1;
    else                w_err_nxt = error;
  end

  // Beat decode from the upcoming state so the beat registers together with
  // the state that issues it.
  always_comb begin
    w_cv  = CV_NONE;
    w_cfg = '0;
    w_cmd = '0;
    w_tap = '0;
    case (w_state_nxt)
      S_SETCFG: begin w_cv = CV_SETTING; w_cfg = r_setting;            end
      S_TAPS:   begin w_cv = CV_TAP;     w_tap = w_buf_rd;             end
      S_START:  begin w_cv = CV_COMMAND; w_cmd = CMD_START;            end
      S_STOP:   begin w_cv = CV_COMMAND; w_cmd = CMD_STOP;             end
      S_RET:    begin w_cv = CV_COMMAND; w_cmd = ret_command(r_flush); end
      default:  w_cv = CV_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_tmo         <= '0;
      r_setting     <= '0;
      r_flush       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      running       <= 1'b0;
      error         <= 1'b0;
      config_valid  <= CV_NONE;
      input_config  <= '0;
      input_command <= '0;
      config_tap    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_tmo         <= w_tmo_nxt;
      if (w_go_acc)   r_setting <= host_setting;
      if (w_stop_acc) r_flush   <= host_flush;
      busy          <= (w_state_nxt != S_IDLE);
      done          <= w_done_nxt;
      running       <= (w_state_nxt == S_RUN);
      error         <= w_err_nxt;
      config_valid  <= w_cv;
      input_config  <= w_cfg;
      input_command <= w_cmd;
      config_tap    <= w_tap;
    end
  end

endmodule
`default_nettype wire
